// File: rtl/sa_aw_arbiter.sv
// -----------------------------------------------------------------------------
// sa_aw_arbiter
//   Per-slave write-address arbiter. Collects AW requests from MST_AMT master
//   dispatchers, grants one at a time in round-robin order, prefixes the
//   winning master index onto AWID (so B can be routed back), tracks in-flight
//   writes (closed by B handshakes) and publishes grant order for the W path.
//
// Ports
//   ACLK_i, ARESETn_i     : clock, synchronous active-low reset
//   dsp_AW*_i             : packed per-master AW payload, master k in slice k
//   dsp_AWVALID_i/READY_o : per-master request / grant (grant is same-cycle)
//   s_AW*_o, s_AWVALID_o  : registered AW toward the slave
//   s_AWREADY_i           : slave AW ready
//   s_BVALID_i/BREADY_i   : observed B handshake, retires one write
//   grant_mst_id_o        : master index of the current/last grant
//   grant_shift_en_o      : pulses on each slave AW handshake
//   outst_ctn_o           : number of writes in flight
//
// Build option
//   SA_AW_OUTST_LIMIT_EN  : when defined, arbitration stalls while
//                           OUTSTANDING_AMT writes are in flight; otherwise
//                           the counter only tracks (and wraps).
// -----------------------------------------------------------------------------
module sa_aw_arbiter #(
   parameter int MST_AMT           = 2,
   parameter int OUTSTANDING_AMT   = 8,
   parameter int OUTST_CTN_W       = $clog2(OUTSTANDING_AMT) + 1,
   parameter int MST_ID_W          = $clog2(MST_AMT),
   parameter int ADDR_WIDTH        = 32,
   parameter int TRANS_MST_ID_W    = 5,
   parameter int TRANS_SLV_ID_W    = MST_ID_W + TRANS_MST_ID_W,
   parameter int TRANS_BURST_W     = 2,
   parameter int TRANS_DATA_LEN_W  = 3,
   parameter int TRANS_DATA_SIZE_W = 3
) (
   input  logic                                   ACLK_i,
   input  logic                                   ARESETn_i,
   input  logic [TRANS_MST_ID_W*MST_AMT-1:0]      dsp_AWID_i,
   input  logic [ADDR_WIDTH*MST_AMT-1:0]          dsp_AWADDR_i,
   input  logic [TRANS_BURST_W*MST_AMT-1:0]       dsp_AWBURST_i,
   input  logic [TRANS_DATA_LEN_W*MST_AMT-1:0]    dsp_AWLEN_i,
   input  logic [TRANS_DATA_SIZE_W*MST_AMT-1:0]   dsp_AWSIZE_i,
   input  logic [MST_AMT-1:0]                     dsp_AWVALID_i,
   output logic [MST_AMT-1:0]                     dsp_AWREADY_o,
   output logic [TRANS_SLV_ID_W-1:0]              s_AWID_o,
   output logic [ADDR_WIDTH-1:0]                  s_AWADDR_o,
   output logic [TRANS_BURST_W-1:0]               s_AWBURST_o,
   output logic [TRANS_DATA_LEN_W-1:0]            s_AWLEN_o,
   output logic [TRANS_DATA_SIZE_W-1:0]           s_AWSIZE_o,
   output logic                                   s_AWVALID_o,
   input  logic                                   s_AWREADY_i,
   input  logic                                   s_BVALID_i,
   input  logic                                   s_BREADY_i,
   output logic [MST_ID_W-1:0]                    grant_mst_id_o,
   output logic                                   grant_shift_en_o,
   output logic [OUTST_CTN_W-1:0]                 outst_ctn_o
);

   typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_e;

   state_e                          state_q, state_d;
   logic [MST_ID_W-1:0]             rr_ptr_q;
   logic [MST_ID_W-1:0]             grant_q;
   logic [OUTST_CTN_W-1:0]          outst_q, outst_d;
   logic [TRANS_SLV_ID_W-1:0]       awid_q;
   logic [ADDR_WIDTH-1:0]           awaddr_q;
   logic [TRANS_BURST_W-1:0]        awburst_q;
   logic [TRANS_DATA_LEN_W-1:0]     awlen_q;
   logic [TRANS_DATA_SIZE_W-1:0]    awsize_q;

   // Per-master views of the packed dispatcher payload
   logic [TRANS_MST_ID_W-1:0]       awid_arr    [MST_AMT];
   logic [ADDR_WIDTH-1:0]           awaddr_arr  [MST_AMT];
   logic [TRANS_BURST_W-1:0]        awburst_arr [MST_AMT];
   logic [TRANS_DATA_LEN_W-1:0]     awlen_arr   [MST_AMT];
   logic [TRANS_DATA_SIZE_W-1:0]    awsize_arr  [MST_AMT];

   logic [MST_AMT-1:0]              prio_mask;
   logic [MST_AMT-1:0]              masked_req;
   logic [MST_AMT-1:0]              pick_src;
   logic [MST_AMT-1:0]              win_onehot;
   logic [MST_ID_W-1:0]             winner_idx;
   logic                            winner_found;
   logic                            arb_allow;
   logic                            grant_now;
   logic                            aw_hs;
   logic                            b_hs;

   genvar gi, gb;

   generate
      for (gi = 0; gi < MST_AMT; gi++) begin : g_mst
         assign awid_arr[gi]    = dsp_AWID_i[gi*TRANS_MST_ID_W +: TRANS_MST_ID_W];
         assign awaddr_arr[gi]  = dsp_AWADDR_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
         assign awburst_arr[gi] = dsp_AWBURST_i[gi*TRANS_BURST_W +: TRANS_BURST_W];
         assign awlen_arr[gi]   = dsp_AWLEN_i[gi*TRANS_DATA_LEN_W +: TRANS_DATA_LEN_W];
         assign awsize_arr[gi]  = dsp_AWSIZE_i[gi*TRANS_DATA_SIZE_W +: TRANS_DATA_SIZE_W];
         // Masters strictly above the last winner get first look
         assign prio_mask[gi]   = (MST_ID_W'(gi) > rr_ptr_q);
      end

      // One-hot to index: bit b of the index is set when the winner's
      // position has bit b set.
      for (gb = 0; gb < MST_ID_W; gb++) begin : g_idx_bit
         logic [MST_AMT-1:0] sel_mask;
         for (gi = 0; gi < MST_AMT; gi++) begin : g_sel
            assign sel_mask[gi] = (((gi >> gb) & 1) != 0);
         end
         assign winner_idx[gb] = |(win_onehot & sel_mask);
      end
   endgenerate

   // Round-robin: lowest requester above rr_ptr, else wrap to lowest overall
   assign masked_req   = dsp_AWVALID_i & prio_mask;
   assign pick_src     = (|masked_req) ? masked_req : dsp_AWVALID_i;
   assign win_onehot   = pick_src & (~pick_src + MST_AMT'(1));
   assign winner_found = |dsp_AWVALID_i;

`ifdef SA_AW_OUTST_LIMIT_EN
   assign arb_allow = (outst_q < OUTST_CTN_W'(OUTSTANDING_AMT));
`else
   assign arb_allow = 1'b1;
`endif

   // Grant depends only on registered state and requests, never on
   // s_AWREADY_i, so there is no ready-to-ready combinational path.
   assign grant_now = (state_q == ST_IDLE) && arb_allow && winner_found;
   assign aw_hs     = (state_q == ST_BUSY) && s_AWREADY_i;
   // A B handshake with nothing outstanding is ignored
   assign b_hs      = s_BVALID_i && s_BREADY_i && (outst_q != '0);

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (grant_now)   state_d = ST_BUSY;
         ST_BUSY: if (s_AWREADY_i) state_d = ST_IDLE;
         default:                  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      outst_d = outst_q;
      if (aw_hs && !b_hs) begin
         outst_d = outst_q + OUTST_CTN_W'(1);
      end else if (!aw_hs && b_hs) begin
         outst_d = outst_q - OUTST_CTN_W'(1);
      end
   end

   always_ff @(posedge ACLK_i) begin
      if (!ARESETn_i) begin
         state_q   <= ST_IDLE;
         rr_ptr_q  <= MST_ID_W'(MST_AMT - 1);
         grant_q   <= '0;
         outst_q   <= '0;
         awid_q    <= '0;
         awaddr_q  <= '0;
         awburst_q <= '0;
         awlen_q   <= '0;
         awsize_q  <= '0;
      end else begin
         state_q <= state_d;
         outst_q <= outst_d;
         if (grant_now) begin
            grant_q   <= winner_idx;
            awid_q    <= {winner_idx, awid_arr[winner_idx]};
            awaddr_q  <= awaddr_arr[winner_idx];
            awburst_q <= awburst_arr[winner_idx];
            awlen_q   <= awlen_arr[winner_idx];
            awsize_q  <= awsize_arr[winner_idx];
         end
         // Pointer only advances once the slave has actually taken the grant
         if (aw_hs) begin
            rr_ptr_q <= grant_q;
         end
      end
   end

   assign dsp_AWREADY_o    = grant_now ? win_onehot : '0;
   assign s_AWVALID_o      = (state_q == ST_BUSY);
   assign s_AWID_o         = awid_q;
   assign s_AWADDR_o       = awaddr_q;
   assign s_AWBURST_o      = awburst_q;
   assign s_AWLEN_o        = awlen_q;
   assign s_AWSIZE_o       = awsize_q;
   assign grant_mst_id_o   = grant_q;
   assign grant_shift_en_o = aw_hs;
   assign outst_ctn_o      = outst_q;

endmodule

// File: tb/tb_sa_aw_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sa_aw_arbiter
//   Directed bench for sa_aw_arbiter with default parameters (2 masters,
//   8 outstanding). Expected slave-side AW transactions are queued by the
//   stimulus; a negedge monitor pops and compares on every slave handshake.
//   Status and handshake signals are checked directly at the negedge.
// -----------------------------------------------------------------------------
module tb_sa_aw_arbiter;

   logic         clk = 1'b0;
   logic         ARESETn_i;
   logic [9:0]   dsp_AWID_i;
   logic [63:0]  dsp_AWADDR_i;
   logic [3:0]   dsp_AWBURST_i;
   logic [5:0]   dsp_AWLEN_i;
   logic [5:0]   dsp_AWSIZE_i;
   logic [1:0]   dsp_AWVALID_i;
   logic [1:0]   dsp_AWREADY_o;
   logic [5:0]   s_AWID_o;
   logic [31:0]  s_AWADDR_o;
   logic [1:0]   s_AWBURST_o;
   logic [2:0]   s_AWLEN_o;
   logic [2:0]   s_AWSIZE_o;
   logic         s_AWVALID_o;
   logic         s_AWREADY_i;
   logic         s_BVALID_i;
   logic         s_BREADY_i;
   logic [0:0]   grant_mst_id_o;
   logic         grant_shift_en_o;
   logic [3:0]   outst_ctn_o;

   always #5 clk = ~clk;

   sa_aw_arbiter dut (
      .ACLK_i           (clk),
      .ARESETn_i        (ARESETn_i),
      .dsp_AWID_i       (dsp_AWID_i),
      .dsp_AWADDR_i     (dsp_AWADDR_i),
      .dsp_AWBURST_i    (dsp_AWBURST_i),
      .dsp_AWLEN_i      (dsp_AWLEN_i),
      .dsp_AWSIZE_i     (dsp_AWSIZE_i),
      .dsp_AWVALID_i    (dsp_AWVALID_i),
      .dsp_AWREADY_o    (dsp_AWREADY_o),
      .s_AWID_o         (s_AWID_o),
      .s_AWADDR_o       (s_AWADDR_o),
      .s_AWBURST_o      (s_AWBURST_o),
      .s_AWLEN_o        (s_AWLEN_o),
      .s_AWSIZE_o       (s_AWSIZE_o),
      .s_AWVALID_o      (s_AWVALID_o),
      .s_AWREADY_i      (s_AWREADY_i),
      .s_BVALID_i       (s_BVALID_i),
      .s_BREADY_i       (s_BREADY_i),
      .grant_mst_id_o   (grant_mst_id_o),
      .grant_shift_en_o (grant_shift_en_o),
      .outst_ctn_o      (outst_ctn_o)
   );

   typedef struct packed {
      logic        mst;
      logic [5:0]  id;
      logic [31:0] addr;
      logic [7:0]  ctl;   // {burst, len, size}
   } aw_exp_t;

   aw_exp_t exp_q[$];
   aw_exp_t mon_e;
   int      n_checks = 0;
   int      n_fail   = 0;
   bit      mon_en   = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Hand-computed slave-side view of each master's fixed payload
   task automatic push_exp(input int m);
      aw_exp_t e;
      if (m == 0) e = '{mst: 1'b0, id: 6'h0A, addr: 32'h1000_0000, ctl: {2'b01, 3'd3, 3'd2}};
      else        e = '{mst: 1'b1, id: 6'h23, addr: 32'h4000_0010, ctl: {2'b10, 3'd7, 3'd3}};
      exp_q.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (mon_en) begin
         if (s_AWVALID_o && s_AWREADY_i) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL sb_unexpected: got AW id=0x%0h addr=0x%0h, expected none", s_AWID_o, s_AWADDR_o);
            end else begin
               mon_e = exp_q.pop_front();
               $display("AW handshake: id=0x%0h addr=0x%0h grant=%0d", s_AWID_o, s_AWADDR_o, grant_mst_id_o);
               chk("sb_awid",  64'(s_AWID_o), 64'(mon_e.id));
               chk("sb_addr",  64'(s_AWADDR_o), 64'(mon_e.addr));
               chk("sb_ctl",   64'({s_AWBURST_o, s_AWLEN_o, s_AWSIZE_o}), 64'(mon_e.ctl));
               chk("sb_grant", 64'(grant_mst_id_o), 64'(mon_e.mst));
               chk("sb_shift", 64'(grant_shift_en_o), 64'd1);
            end
         end else begin
            chk("shift_idle", 64'(grant_shift_en_o), 64'd0);
         end
         if (s_AWVALID_o) chk("busy_rdy", 64'(dsp_AWREADY_o), 64'd0);
      end
   end

   logic [1:0] rr_exp [8];

   initial begin
      rr_exp = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
      ARESETn_i     = 1'b0;
      dsp_AWVALID_i = 2'b00;
      s_AWREADY_i   = 1'b0;
      s_BVALID_i    = 1'b0;
      s_BREADY_i    = 1'b0;
      dsp_AWID_i    = {5'h03, 5'h0A};
      dsp_AWADDR_i  = {32'h4000_0010, 32'h1000_0000};
      dsp_AWBURST_i = {2'b10, 2'b01};
      dsp_AWLEN_i   = {3'd7, 3'd3};
      dsp_AWSIZE_i  = {3'd3, 3'd2};

      // Reset state
      step(); step();
      @(negedge clk);
      chk("rst_vld",   64'(s_AWVALID_o), 64'd0);
      chk("rst_rdy",   64'(dsp_AWREADY_o), 64'd0);
      chk("rst_shift", 64'(grant_shift_en_o), 64'd0);
      chk("rst_id",    64'(s_AWID_o), 64'd0);
      chk("rst_addr",  64'(s_AWADDR_o), 64'd0);
      chk("rst_grant", 64'(grant_mst_id_o), 64'd0);
      chk("rst_cnt",   64'(outst_ctn_o), 64'd0);
      step();
      ARESETn_i = 1'b1;
      mon_en    = 1'b1;

      // Single request from master 1
      dsp_AWVALID_i = 2'b10;
      push_exp(1);
      @(negedge clk);
      chk("t1_rdy", 64'(dsp_AWREADY_o), 64'h2);
      step();
      dsp_AWVALID_i = 2'b00;
      s_AWREADY_i   = 1'b1;
      @(negedge clk);
      chk("t1_vld",   64'(s_AWVALID_o), 64'd1);
      chk("t1_id",    64'(s_AWID_o), 64'h23);
      chk("t1_grant", 64'(grant_mst_id_o), 64'd1);
      step();
      s_AWREADY_i = 1'b0;
      @(negedge clk);
      chk("t1_cnt",     64'(outst_ctn_o), 64'd1);
      chk("t1_vld_off", 64'(s_AWVALID_o), 64'd0);

      // Round-robin, both masters, slave always ready
      step();
      dsp_AWVALID_i = 2'b11;
      s_AWREADY_i   = 1'b1;
      push_exp(0); push_exp(1); push_exp(0); push_exp(1);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("rr_rdy", 64'(dsp_AWREADY_o), 64'(rr_exp[i]));
         step();
      end
      dsp_AWVALID_i = 2'b00;
      s_AWREADY_i   = 1'b0;
      @(negedge clk);
      chk("rr_cnt", 64'(outst_ctn_o), 64'd5);

      // Slave backpressure for 5 cycles, master 1 waiting meanwhile
      step();
      dsp_AWVALID_i = 2'b01;
      push_exp(0);
      @(negedge clk);
      chk("bp_rdy", 64'(dsp_AWREADY_o), 64'h1);
      step();
      dsp_AWVALID_i = 2'b10;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_vld",  64'(s_AWVALID_o), 64'd1);
         chk("bp_addr", 64'(s_AWADDR_o), 64'h1000_0000);
         chk("bp_id",   64'(s_AWID_o), 64'h0A);
         step();
      end
      s_AWREADY_i = 1'b1;
      push_exp(1);
      @(negedge clk);
      chk("bp_vld6", 64'(s_AWVALID_o), 64'd1);
      step();
      @(negedge clk);
      chk("bp_next_rdy", 64'(dsp_AWREADY_o), 64'h2);
      step();
      dsp_AWVALID_i = 2'b00;
      @(negedge clk);
      step();
      s_AWREADY_i = 1'b0;
      @(negedge clk);
      chk("bp_cnt", 64'(outst_ctn_o), 64'd7);

      // Fill to 8 outstanding
      step();
      dsp_AWVALID_i = 2'b01;
      s_AWREADY_i   = 1'b1;
      push_exp(0);
      step();
      dsp_AWVALID_i = 2'b00;
      step();
      s_AWREADY_i = 1'b0;
      @(negedge clk);
      chk("full_cnt", 64'(outst_ctn_o), 64'd8);

      // Request at count 8, then one B handshake
      step();
      dsp_AWVALID_i = 2'b01;
      @(negedge clk);
`ifdef SA_AW_OUTST_LIMIT_EN
      chk("full_rdy", 64'(dsp_AWREADY_o), 64'h0);
`else
      chk("full_rdy", 64'(dsp_AWREADY_o), 64'h1);
      push_exp(0);
`endif
      step();
      s_BVALID_i = 1'b1;
      s_BREADY_i = 1'b1;
      @(negedge clk);
      chk("full_rdy_b", 64'(dsp_AWREADY_o), 64'h0);
      step();
      s_BVALID_i  = 1'b0;
      s_BREADY_i  = 1'b0;
      s_AWREADY_i = 1'b1;
`ifdef SA_AW_OUTST_LIMIT_EN
      push_exp(0);
      @(negedge clk);
      chk("full_cnt7", 64'(outst_ctn_o), 64'd7);
      chk("full_rdy7", 64'(dsp_AWREADY_o), 64'h1);
`else
      @(negedge clk);
      chk("full_cnt7", 64'(outst_ctn_o), 64'd7);
      chk("full_rdy7", 64'(dsp_AWREADY_o), 64'h0);
`endif
      step();
      dsp_AWVALID_i = 2'b00;
      step();
      s_AWREADY_i = 1'b0;
      @(negedge clk);
      chk("full_cnt8b", 64'(outst_ctn_o), 64'd8);

      // Drain to 3 with B handshakes
      step();
      s_BVALID_i = 1'b1;
      s_BREADY_i = 1'b1;
      repeat (5) step();
      s_BVALID_i = 1'b0;
      s_BREADY_i = 1'b0;
      @(negedge clk);
      chk("sim_cnt3a", 64'(outst_ctn_o), 64'd3);

      // AW and B handshake in the same cycle at count 3
      step();
      dsp_AWVALID_i = 2'b10;
      s_AWREADY_i   = 1'b1;
      push_exp(1);
      step();
      dsp_AWVALID_i = 2'b00;
      s_BVALID_i    = 1'b1;
      s_BREADY_i    = 1'b1;
      @(negedge clk);
      step();
      s_BVALID_i  = 1'b0;
      s_BREADY_i  = 1'b0;
      s_AWREADY_i = 1'b0;
      @(negedge clk);
      chk("sim_cnt3", 64'(outst_ctn_o), 64'd3);

      // Drain to 0, then a B handshake at 0
      step();
      s_BVALID_i = 1'b1;
      s_BREADY_i = 1'b1;
      repeat (3) step();
      @(negedge clk);
      chk("drain_cnt0", 64'(outst_ctn_o), 64'd0);
      step();
      s_BVALID_i = 1'b0;
      s_BREADY_i = 1'b0;
      @(negedge clk);
      chk("b_at_zero", 64'(outst_ctn_o), 64'd0);

      // One write from master 0 leaves rr pointer at 0
      step();
      dsp_AWVALID_i = 2'b01;
      s_AWREADY_i   = 1'b1;
      push_exp(0);
      step();
      dsp_AWVALID_i = 2'b00;
      @(negedge clk);
      step();
      s_AWREADY_i   = 1'b0;
      dsp_AWVALID_i = 2'b10;
      @(negedge clk);
      chk("mr_rdy", 64'(dsp_AWREADY_o), 64'h2);
      step();
      dsp_AWVALID_i = 2'b00;
      @(negedge clk);
      chk("mr_busy",    64'(s_AWVALID_o), 64'd1);
      chk("mr_cnt_pre", 64'(outst_ctn_o), 64'd1);

      // Reset while BUSY
      step();
      ARESETn_i = 1'b0;
      step();
      ARESETn_i     = 1'b1;
      dsp_AWVALID_i = 2'b11;
      @(negedge clk);
      chk("mr_vld",   64'(s_AWVALID_o), 64'd0);
      chk("mr_cnt",   64'(outst_ctn_o), 64'd0);
      chk("mr_grant", 64'(grant_mst_id_o), 64'd0);
      chk("mr_tie",   64'(dsp_AWREADY_o), 64'h1);
      push_exp(0);
      step();
      dsp_AWVALID_i = 2'b00;
      s_AWREADY_i   = 1'b1;
      @(negedge clk);
      step();
      s_AWREADY_i = 1'b0;
      @(negedge clk);
      chk("mr_cnt1", 64'(outst_ctn_o), 64'd1);

      repeat (3) step();
      chk("sb_drain", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sa_aw_arbiter.md
# sa_aw_arbiter

Per-slave write-address arbiter for the interconnect's slave-arbitration stage. It accepts AW requests from `MST_AMT` master-side dispatchers and grants them round-robin to one slave port. The winning master index is prepended to AWID so the write-response path can route B back to that master. A per-slave outstanding-write counter, closed by B handshakes, throttles new grants. The block also publishes grant order so the W-channel path can steer write data.

## Interface

Parameters:

- `MST_AMT`, 2: number of master dispatchers.
- `OUTSTANDING_AMT`, 8: maximum in-flight writes to this slave.
- `OUTST_CTN_W`, `$clog2(OUTSTANDING_AMT)+1`: outstanding counter width.
- `MST_ID_W`, `$clog2(MST_AMT)`: master index width.
- `ADDR_WIDTH`, 32: AWADDR width.
- `TRANS_MST_ID_W`, 5: master transaction ID width.
- `TRANS_SLV_ID_W`, `MST_ID_W+TRANS_MST_ID_W`: AWID width toward the slave.
- `TRANS_BURST_W`, 2: AWBURST width.
- `TRANS_DATA_LEN_W`, 3: AWLEN width.
- `TRANS_DATA_SIZE_W`, 3: AWSIZE width.

Ports:

- Clock and reset:
  - `ACLK_i` in 1: the single clock.
  - `ARESETn_i` in 1: reset; synchronous, active-low.
- Dispatcher side, packed with master k in slice k:
  - `dsp_AWID_i` in `TRANS_MST_ID_W*MST_AMT`
  - `dsp_AWADDR_i` in `ADDR_WIDTH*MST_AMT`
  - `dsp_AWBURST_i` in `TRANS_BURST_W*MST_AMT`
  - `dsp_AWLEN_i` in `TRANS_DATA_LEN_W*MST_AMT`
  - `dsp_AWSIZE_i` in `TRANS_DATA_SIZE_W*MST_AMT`
  - `dsp_AWVALID_i` in `MST_AMT`
  - `dsp_AWREADY_o` out `MST_AMT`
- Slave side:
  - `s_AWID_o` out `TRANS_SLV_ID_W`: `{master index, AWID}`.
  - `s_AWADDR_o`, `s_AWBURST_o`, `s_AWLEN_o`, `s_AWSIZE_o` out: registered payload.
  - `s_AWVALID_o` out 1.
  - `s_AWREADY_i` in 1.
- B handshake observation:
  - `s_BVALID_i` in 1: slave BVALID.
  - `s_BREADY_i` in 1: BREADY driven to the slave.
- Grant order to the W path:
  - `grant_mst_id_o` out `MST_ID_W`: currently granted master.
  - `grant_shift_en_o` out 1: one-cycle pulse on slave AW handshake.
- Status:
  - `outst_ctn_o` out `OUTST_CTN_W`: in-flight write count.

## Operation

- Two-state FSM.
  - **IDLE**, reset state. Arbitration runs only here and only while `outst_ctn_o < OUTSTANDING_AMT`.
  - **BUSY**. Holds the granted request until the slave accepts it.
- Arbitration in IDLE:
  - Round-robin search begins at `(rr_ptr+1) mod MST_AMT`; the first asserted `dsp_AWVALID_i` bit wins.
  - In the same cycle, `dsp_AWREADY_o[winner]=1` combinationally and every other bit is 0.
  - The winner's payload is registered into the `s_AW*_o` registers, with `s_AWID_o={winner, dsp_AWID}`. The grant register takes `winner` and the FSM moves to BUSY.
- BUSY:
  - `s_AWVALID_o=1` and the payload stays stable. All `dsp_AWREADY_o` are 0.
  - On `s_AWREADY_i=1`: pulse `grant_shift_en_o`, set `rr_ptr<=grant`, increment the counter, return to IDLE.
  - Minimum spacing between grants is 2 cycles.
- `grant_mst_id_o` equals the grant register at all times; it is valid whenever `grant_shift_en_o=1`.
- Outstanding counter:
  - +1 on slave AW handshake (`s_AWVALID_o & s_AWREADY_i`).
  - −1 on `s_BVALID_i & s_BREADY_i`.
  - Both events in the same cycle leave it unchanged.
  - A B handshake at count 0 is ignored (saturates at 0). The count never exceeds `OUTSTANDING_AMT`.
- Full condition: when count == `OUTSTANDING_AMT`, IDLE grants nothing and all `dsp_AWREADY_o` are 0. Arbitration resumes in the cycle after the count drops.
- A dispatcher that deasserts AWVALID before it is granted loses nothing; the search simply skips it.

## Timing

- Reset values:
  - `s_AWVALID_o=0`, `dsp_AWREADY_o=0`, `grant_shift_en_o=0`.
  - `s_AW*_o=0`, `grant_mst_id_o=0`, `outst_ctn_o=0`.
  - `rr_ptr=MST_AMT-1`, so master 0 has first priority. FSM = IDLE.
- Latency: dispatcher handshake in cycle N gives `s_AWVALID_o=1` in cycle N+1. It stays asserted until `s_AWREADY_i`.
- The counter updates on the clock edge after the handshake, and `outst_ctn_o` is registered.
- Reset asserted mid-BUSY: the pending request is dropped and all state returns to reset values on the next edge.
- No combinational path from `s_AWREADY_i` to `dsp_AWREADY_o`.

## Configuration

- `SA_AW_OUTST_LIMIT_EN`:
  - Defined: the counter gates arbitration as described above.
  - Undefined: the counter and `outst_ctn_o` still track, but arbitration ignores them; the full condition never blocks and the counter wraps modulo `2^OUTST_CTN_W`.

## Test plan

- **Single request.** Reset, then `dsp_AWVALID_i=2'b10` with AWID=5'h03 and AWADDR=32'h4000_0010.
  - Same cycle: `dsp_AWREADY_o=2'b10`.
  - Next cycle: `s_AWVALID_o=1`, `s_AWID_o=6'h23`.
  - `s_AWREADY_i=1` then gives `grant_shift_en_o` pulse, `grant_mst_id_o=1`, and `outst_ctn_o=1` one cycle later.
- **Round-robin.** Both masters request continuously, slave always ready. Grant sequence is 0,1,0,1, with a grant every 2 cycles.
- **Slave backpressure.** `s_AWREADY_i=0` for 5 cycles. `s_AWVALID_o` and the payload stay constant and `dsp_AWREADY_o` stays 0 throughout; the handshake completes in cycle 6.
- **Full throttle** (macro defined). With OUTSTANDING_AMT=8, issue 8 writes and no B.
  - `outst_ctn_o=8` and no further `dsp_AWREADY_o` despite a valid request.
  - One B handshake gives count 7, then a grant in the following cycle.
- **Simultaneous events.** AW handshake and B handshake in the same cycle at count 3 leave the count at 3. A B handshake at count 0 leaves it at 0.
- **Mid-operation reset.** Assert `ARESETn_i=0` while in BUSY. Next cycle `s_AWVALID_o=0` and `outst_ctn_o=0`, and master 0 wins the first post-reset tie.
